// File: rtl/act_streamer.sv
// act_streamer
//   Holds one n x n frame of N-bit pixels loaded by the host and streams it,
//   in raster order, to a pooled accelerator as a ce-qualified activation
//   stream. After the last pixel the block keeps ce high with zero data to
//   drain the accelerator pipeline until end_op arrives, or until FLUSH_MAX
//   flush cycles have elapsed (timeout).
//
// Ports
//   clk          rising-edge clock
//   global_rst   asynchronous active-high reset (buffer contents survive it)
//   wr_en        host write strobe; accepted only while idle and in range
//   wr_addr      raster index of the pixel being written
//   wr_data      pixel value being written
//   start        one-cycle frame request, honoured only in IDLE
//   hold         downstream stall: freezes the stream and all transitions
//   end_op       end-of-frame from the accelerator, honoured only in FLUSH
//   ce           registered clock enable to the accelerator
//   activation   registered pixel qualified by ce
//   busy         high whenever the FSM is not IDLE
//   done         one-cycle frame-complete pulse
//   timeout      sticky: the last frame ended on flush timeout
module act_streamer #(
  parameter int n         = 10,
  parameter int N         = 16,
  parameter int AW        = 7,
  parameter int FLUSH_MAX = 64
) (
  input  logic          clk,
  input  logic          global_rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic          start,
  input  logic          hold,
  input  logic          end_op,
  output logic          ce,
  output logic [N-1:0]  activation,
  output logic          busy,
  output logic          done,
  output logic          timeout
);

  localparam int PIX = n * n;
  localparam int FW  = $clog2(FLUSH_MAX + 1);

  localparam logic [AW-1:0] LAST_PTR    = AW'(PIX - 1);
  localparam logic [AW:0]   PIX_COUNT   = (AW + 1)'(PIX);
  localparam logic [FW-1:0] FLUSH_LIMIT = FW'(FLUSH_MAX);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t         state_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [FW-1:0]  flush_cnt_reg;
  logic           wr_ok;

  // Pixel buffer. Deliberately outside the reset domain so a frame aborted
  // by reset can be replayed from the same contents.
  logic [N-1:0] pix_mem [0:PIX-1];

  assign busy  = (state_reg != IDLE);
  // Widen the address by one bit so the range check never wraps.
  assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < PIX_COUNT);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      pix_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state_reg     <= IDLE;
      rd_ptr_reg    <= '0;
      flush_cnt_reg <= '0;
      ce            <= 1'b0;
      activation    <= '0;
      done          <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      // ce and done are pulses; activation holds unless a ce cycle is issued.
      ce   <= 1'b0;
      done <= 1'b0;
      // A stall freezes everything, including leaving DONE or accepting start.
      if (!hold) begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              state_reg     <= STREAM;
              rd_ptr_reg    <= '0;
              flush_cnt_reg <= '0;
              timeout       <= 1'b0;
            end
          end
          STREAM: begin
            ce         <= 1'b1;
            activation <= pix_mem[rd_ptr_reg];
            if (rd_ptr_reg == LAST_PTR) begin
              state_reg <= FLUSH;
            end else begin
              rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
          end
          FLUSH: begin
            // end_op takes priority over an expiring flush budget.
            if (end_op) begin
              state_reg <= DONE;
              done      <= 1'b1;
              timeout   <= 1'b0;
            end else if (flush_cnt_reg == FLUSH_LIMIT) begin
              state_reg <= DONE;
              done      <= 1'b1;
              timeout   <= 1'b1;
            end else begin
              ce            <= 1'b1;
              activation    <= '0;
              flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
          end
          DONE: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_act_streamer.sv
module tb_act_streamer;

  localparam int NPIX = 100;
  localparam int FMAX = 64;

  logic        clk = 1'b0;
  logic        global_rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        end_op = 1'b0;
  logic        ce;
  logic [15:0] activation;
  logic        busy;
  logic        done;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  act_streamer #(.n(10), .N(16), .AW(7), .FLUSH_MAX(FMAX)) dut (
    .clk        (clk),
    .global_rst (global_rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .hold       (hold),
    .end_op     (end_op),
    .ce         (ce),
    .activation (activation),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is described by how many pixels and flush beats have gone out;
  // outputs follow from those counts directly.
  logic [15:0] m_mem [0:NPIX-1];
  bit          m_in_frame = 0;
  bit          m_in_done = 0;
  int          m_pix = 0;
  int          m_fl = 0;
  logic        m_ce = 0;
  logic [15:0] m_act = '0;
  logic        m_done = 0;
  logic        m_to = 0;

  always @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      m_in_frame = 0; m_in_done = 0; m_pix = 0; m_fl = 0;
      m_ce = 0; m_act = '0; m_done = 0; m_to = 0;
    end else begin
      if (wr_en && !(m_in_frame || m_in_done) && int'(wr_addr) < NPIX)
        m_mem[wr_addr] = wr_data;
      m_ce = 0;
      m_done = 0;
      if (!hold) begin
        if (m_in_done) begin
          m_in_done = 0;
        end else if (!m_in_frame) begin
          if (start) begin
            m_in_frame = 1; m_pix = 0; m_fl = 0; m_to = 0;
          end
        end else if (m_pix < NPIX) begin
          m_ce = 1; m_act = m_mem[m_pix]; m_pix++;
        end else if (end_op || m_fl == FMAX) begin
          m_to = !end_op;
          m_done = 1; m_in_frame = 0; m_in_done = 1;
        end else begin
          m_ce = 1; m_act = '0; m_fl++;
        end
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (!global_rst) begin
      chk("ce", ce, m_ce);
      chk("activation", activation, m_act);
      chk("busy", busy, m_in_frame || m_in_done);
      chk("done", done, m_done);
      chk("timeout", timeout, m_to);
    end
  end

  // Per-frame observation for literal expectations.
  int          ce_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] act_q[$];

  always @(negedge clk) begin
    if (!global_rst) begin
      if (ce) begin
        ce_cnt++;
        act_q.push_back(activation);
      end
      if (done) done_cnt++;
    end
  end

  task automatic clear_obs();
    ce_cnt = 0; done_cnt = 0; act_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cycles);
    int i;
    for (i = 0; i < max_cycles; i++) begin
      tick();
      if (done) break;
    end
    if (i == max_cycles) chk("wait_done_bound", 0, 1);
  endtask

  // Expected stream: pixels 0..99 (buf[i]=i) then nflush zeros.
  task automatic chk_seq(input string nm, input int nflush);
    int bad = 0;
    chk({nm, "_len"}, act_q.size(), NPIX + nflush);
    foreach (act_q[i]) begin
      if (act_q[i] !== ((i < NPIX) ? 16'(i) : 16'h0)) bad++;
    end
    chk({nm, "_content_mismatches"}, bad, 0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_ce", ce, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_activation", activation, 0);
    #2 global_rst = 1'b0;
    tick();

    // Load buf[i] = i
    for (int i = 0; i < NPIX; i++) begin
      wr_en = 1; wr_addr = 7'(i); wr_data = 16'(i);
      tick();
    end
    wr_en = 0;
    tick();

    // Frame A: end_op after 5 flush beats
    clear_obs();
    start = 1; tick(); start = 0;
    repeat (105) tick();
    end_op = 1; tick(); end_op = 0;
    chk("A_done", done, 1);
    chk("A_timeout", timeout, 0);
    tick();
    chk("A_ce_cnt", ce_cnt, 105);
    chk("A_done_cnt", done_cnt, 1);
    chk_seq("A_seq", 5);
    $display("frame A: ce=%0d done=%0d timeout=%0b", ce_cnt, done_cnt, timeout);

    // Frame B: 3-cycle stall after pixel 40, end_op on first flush beat
    clear_obs();
    start = 1; tick(); start = 0;
    repeat (41) tick();
    chk("B_pix40_ce", ce, 1);
    chk("B_pix40_act", activation, 40);
    hold = 1;
    repeat (3) begin
      tick();
      chk("B_hold_ce", ce, 0);
      chk("B_hold_act", activation, 40);
    end
    hold = 0;
    tick();
    chk("B_pix41_act", activation, 41);
    repeat (58) tick();
    end_op = 1; tick(); end_op = 0;
    chk("B_done", done, 1);
    tick();
    chk("B_ce_cnt", ce_cnt, 100);
    chk_seq("B_seq", 0);
    $display("frame B: ce=%0d done=%0d timeout=%0b", ce_cnt, done_cnt, timeout);

    // Frame C: no end_op -> flush timeout
    clear_obs();
    start = 1; tick(); start = 0;
    wait_done(300);
    chk("C_timeout", timeout, 1);
    tick();
    chk("C_ce_cnt", ce_cnt, 100 + FMAX);
    chk("C_timeout_sticky", timeout, 1);
    chk_seq("C_seq", FMAX);
    $display("frame C: ce=%0d done=%0d timeout=%0b", ce_cnt, done_cnt, timeout);

    // Dropped writes: out of range in IDLE, in range while busy; start ignored mid-stream
    wr_en = 1; wr_addr = 7'd100; wr_data = 16'hFFFF; tick(); wr_en = 0;
    clear_obs();
    start = 1; tick(); start = 0;
    chk("D_timeout_cleared", timeout, 0);
    end_op = 1;  // ignored throughout STREAM
    wr_en = 1; wr_addr = 7'd3; wr_data = 16'hBEEF; tick(); wr_en = 0;
    repeat (18) tick();
    start = 1; tick(); start = 0;
    wait_done(300);
    end_op = 0;
    chk("D_timeout", timeout, 0);
    tick();
    chk("D_ce_cnt", ce_cnt, 100);
    chk_seq("D_seq", 0);
    $display("frame D: ce=%0d done=%0d timeout=%0b", ce_cnt, done_cnt, timeout);

    // Frame E: async reset at pixel 50
    clear_obs();
    start = 1; tick(); start = 0;
    repeat (51) tick();
    chk("E_pix50_act", activation, 50);
    #2 global_rst = 1'b1;
    #1;
    chk("E_rst_ce", ce, 0);
    chk("E_rst_busy", busy, 0);
    chk("E_rst_done", done, 0);
    chk("E_rst_act", activation, 0);
    #3 global_rst = 1'b0;
    tick();
    chk("E_no_done", done_cnt, 0);

    // Frame F: replay after reset; end_op on the same edge as flush limit
    clear_obs();
    start = 1; tick(); start = 0;
    repeat (100 + FMAX) tick();
    end_op = 1; tick(); end_op = 0;
    chk("F_done", done, 1);
    chk("F_timeout", timeout, 0);
    tick();
    chk("F_ce_cnt", ce_cnt, 100 + FMAX);
    chk("F_done_cnt", done_cnt, 1);
    chk_seq("F_seq", FMAX);
    $display("frame F: ce=%0d done=%0d timeout=%0b", ce_cnt, done_cnt, timeout);

    // Randomized traffic checked by the model
    for (int c = 0; c < 4000; c++) begin
      start  = ($urandom_range(0, 15) == 0);
      hold   = ($urandom_range(0, 4) == 0);
      end_op = ($urandom_range(0, 11) == 0);
      wr_en  = ($urandom_range(0, 7) == 0);
      wr_addr = 7'($urandom_range(0, 127));
      wr_data = 16'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 global_rst = 1'b1;
        #2 global_rst = 1'b0;
      end
      tick();
    end
    start = 0; hold = 0; end_op = 0; wr_en = 0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/act_streamer.md
ACT_STREAMER -- requirements
Module: act_streamer

Interface
REQ-001 Parameter n, default 10: side length of the square input image, in pixels.
REQ-002 Parameter N, default 16: pixel datapath width in bits.
REQ-003 Parameter AW, default 7: buffer address width; the SHALL hold 2**AW >= n*n.
REQ-004 Parameter FLUSH_MAX, default 64: maximum number of flush cycles before a timeout is declared.
REQ-005 clk  in  1  single clock; all logic is rising-edge triggered.
REQ-006 global_rst  in  1  asynchronous, active-high reset.
REQ-007 wr_en  in  1  host load strobe for the pixel buffer.
REQ-008 wr_addr  in  AW  raster index of the pixel being loaded.
REQ-009 wr_data  in  N  pixel value being loaded.
REQ-010 start  in  1  single-cycle request to stream one frame.
REQ-011 hold  in  1  downstream stall request.
REQ-012 end_op  in  1  end-of-frame indication from the pooled accelerator output.
REQ-013 ce  out  1  registered clock-enable to the accelerator.
REQ-014 activation  out  N  registered pixel presented with ce.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 done  out  1  single-cycle frame-complete pulse.
REQ-017 timeout  out  1  sticky flag: the last frame ended on flush timeout.

Function
REQ-018 The block SHALL contain an n*n x N buffer; a write occurs on clk when wr_en=1, busy=0 and wr_addr<n*n; all other writes are dropped.
REQ-019 The FSM SHALL have states IDLE, STREAM, FLUSH and DONE.
REQ-020 start=1 in IDLE SHALL move the FSM to STREAM, clear rd_ptr, flush_cnt and timeout; start in any other state SHALL be ignored.
REQ-021 In STREAM with hold=0, the cycle after each edge SHALL show ce=1 and activation=buf[rd_ptr], then rd_ptr increments; the first pixel (buf[0]) appears the cycle after start is sampled.
REQ-022 hold=1 sampled at an edge SHALL drive ce=0 on the next cycle, freeze activation, rd_ptr and flush_cnt, and block every state transition except reset.
REQ-023 Exactly n*n ce=1 cycles SHALL occur in STREAM, in raster order with no skipped or repeated pixel; the FSM SHALL enter FLUSH after pixel n*n-1 is issued.
REQ-024 In FLUSH with hold=0, ce=1 with activation=0, and flush_cnt SHALL increment each cycle to drain the accelerator pipeline.
REQ-025 In FLUSH, end_op=1 SHALL move the FSM to DONE with timeout=0; flush_cnt reaching FLUSH_MAX with no end_op SHALL move it to DONE with timeout=1; if both happen on the same edge, end_op wins.
REQ-026 end_op sampled in IDLE, STREAM or DONE SHALL be ignored.
REQ-027 DONE SHALL last one cycle with ce=0, done=1, then return to IDLE; a start sampled during DONE is ignored.
REQ-028 In IDLE and DONE, ce SHALL be 0 and activation SHALL hold its last value.
REQ-029 Total ce=1 cycles per frame SHALL equal n*n + (flush cycles completed before exit).

Reset
REQ-030 global_rst=1 SHALL immediately force state IDLE, ce=0, activation=0, busy=0, done=0, timeout=0, rd_ptr=0 and flush_cnt=0, independent of clk.
REQ-031 Reset mid-frame SHALL abort the frame with no done pulse; buffer contents are not reset and remain valid afterwards.

Verification
REQ-032 Load buf[i]=i for i=0..99, start, hold=0, end_op asserted 5 cycles into FLUSH -> 100 consecutive ce cycles with activation 0..99, 5 flush cycles at 0, done pulses once, timeout=0.
REQ-033 Same load, hold=1 for 3 cycles after pixel 40 -> ce low for exactly 3 cycles, activation stays 40 (value of pixel 40), pixel 41 follows, total 100 data pixels.
REQ-034 end_op never asserted -> exactly 64 flush ce cycles, then done=1 and timeout=1; next start clears timeout.
REQ-035 wr_en during busy and wr_addr=100 in IDLE -> buffer unchanged; start during STREAM -> no restart.
REQ-036 global_rst pulsed at pixel 50 -> ce, busy, done =0 asynchronously; new start replays pixels 0..99 from the preserved buffer.
REQ-037 end_op=1 during STREAM, and end_op with flush_cnt=FLUSH_MAX on the same edge -> the first is ignored; the second gives done with timeout=0.
